// File: rtl/div_unit.sv
// Iterative 32-bit radix-2 restoring divider (MIPS DIV/DIVU), one quotient bit per cycle.
// Define DIV_ZERO_DETECT_EN to short-circuit a zero divisor to a 64'h0 result in two edges.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic [1:0]  dbg_state
);

  // Handshake: start_i is held high until ready_o is seen. ready_o is high
  // only in S_END and drops on the edge where start_i is sampled low.
  // start_i outside S_FREE and annul_i in S_END are ignored.
  typedef enum logic [1:0] {
    S_FREE    = 2'd0,
    S_BY_ZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] rem;
  logic [31:0] dvd;
  logic [31:0] divisor;
  logic        sgn;
  logic        neg1;
  logic        neg2;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] sh_rem;
  logic [31:0] diff;
  logic        fits;
  logic [31:0] rem_nxt;
  logic [31:0] dvd_nxt;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign dbg_state = state;

  always_comb begin
    a_mag = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    b_mag = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
    // The running remainder is always below the divisor, so after the shift
    // it needs only 33 bits and a successful trial fits back into 32.
    sh_rem  = {rem, dvd[31]};
    fits    = (sh_rem >= {1'b0, divisor});
    diff    = sh_rem[31:0] - divisor;
    rem_nxt = fits ? diff : sh_rem[31:0];
    dvd_nxt = {dvd[30:0], fits};
    q_fix   = (sgn && (neg1 ^ neg2)) ? -dvd_nxt : dvd_nxt;
    r_fix   = (sgn && neg1) ? -rem_nxt : rem_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FREE;
      cnt      <= 5'd0;
      rem      <= 32'd0;
      dvd      <= 32'd0;
      divisor  <= 32'd0;
      sgn      <= 1'b0;
      neg1     <= 1'b0;
      neg2     <= 1'b0;
      result_o <= 64'h0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        S_FREE: begin
          if (start_i && !annul_i) begin
            cnt     <= 5'd0;
            rem     <= 32'd0;
            dvd     <= a_mag;
            divisor <= b_mag;
            sgn     <= signed_div_i;
            neg1    <= signed_div_i & opdata1_i[31];
            neg2    <= signed_div_i & opdata2_i[31];
`ifdef DIV_ZERO_DETECT_EN
            if (opdata2_i == 32'd0) state <= S_BY_ZERO;
            else                    state <= S_ON;
`else
            state   <= S_ON;
`endif
          end
        end
`ifdef DIV_ZERO_DETECT_EN
        S_BY_ZERO: begin
          if (annul_i) begin
            state <= S_FREE;
          end else begin
            state    <= S_END;
            result_o <= 64'h0;
            ready_o  <= 1'b1;
          end
        end
`endif
        S_ON: begin
          if (annul_i) begin
            state <= S_FREE;
          end else begin
            rem <= rem_nxt;
            dvd <= dvd_nxt;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state    <= S_END;
              result_o <= {r_fix, q_fix};
              ready_o  <= 1'b1;
            end
          end
        end
        S_END: begin
          if (!start_i) begin
            state   <= S_FREE;
            ready_o <= 1'b0;
          end
        end
        default: state <= S_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed corner cases plus random DIV/DIVU against an arithmetic model.
// Expectations follow DIV_ZERO_DETECT_EN the same way the design does.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        annul;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .annul_i      (annul),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .result_o     (result),
    .ready_o      (ready),
    .dbg_state    (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, with the two cases SV arithmetic
  // does not define the way the hardware does handled explicitly.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    int sa;
    int sb;
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
`ifdef DIV_ZERO_DETECT_EN
      return 64'h0;
`else
      q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      return {a, q};
`endif
    end
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction

  function automatic int ref_lat(input logic [31:0] b);
`ifdef DIV_ZERO_DETECT_EN
    if (b == 32'd0) return 2;
`endif
    return 33;
  endfunction

  logic [63:0] last_res = 64'h0;

  // Latency counts posedges from the accepting edge (edge 1) until ready_o is seen.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input bit toggle, input string tag);
    logic [63:0] exp;
    int n;
    bit seen;
    exp = ref_div(a, b, sgn);
    @(negedge clk);
    opdata1 = a;
    opdata2 = b;
    signed_div = sgn;
    start = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ready) begin
        seen = 1;
      end else if (n >= 2) begin
        opdata1 = $urandom;
        opdata2 = $urandom;
        signed_div = 1'($urandom_range(0, 1));
        start = (toggle && n < 25) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    check({tag, "_lat"}, 64'(n), 64'(ref_lat(b)));
    check({tag, "_res"}, result, exp);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_rdy_drop"}, 64'(ready), 64'd0);
    check({tag, "_hold"}, result, exp);
    last_res = exp;
  endtask

  initial begin
    bit rose;
    logic [31:0] a;
    logic [31:0] b;
    logic s;
    rst = 1'b1;
    start = 1'b0;
    annul = 1'b0;
    signed_div = 1'b0;
    opdata1 = 32'd0;
    opdata2 = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_res", result, 64'h0);
    check("reset_rdy", 64'(ready), 64'd0);

    run_div(32'd100, 32'd7, 1'b0, 0, "divu_100_7");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "div_m7_2");
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0, "div_7_m2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "div_ovf");
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0, "divu_max_1");
    run_div(32'h0000_1234, 32'd0, 1'b0, 0, "divu_by0");
    run_div(32'hFFFF_EDCC, 32'd0, 1'b1, 0, "div_neg_by0");
    run_div(32'd12345, 32'd1000, 1'b1, 1, "div_toggle");

    // Annul at iteration 10: no result, prior result kept.
    @(negedge clk);
    opdata1 = 32'd100;
    opdata2 = 32'd7;
    signed_div = 1'b0;
    start = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    annul = 1'b0;
    rose = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (ready) rose = 1;
    end
    check("annul_no_rdy", 64'(rose), 64'd0);
    check("annul_hold", result, last_res);
    run_div(32'd9, 32'd3, 1'b0, 0, "divu_9_3");

    // Reset mid-iteration aborts and clears the result.
    @(negedge clk);
    opdata1 = 32'd100;
    opdata2 = 32'd7;
    start = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_res", result, 64'h0);
    check("rst_mid_rdy", 64'(ready), 64'd0);
    rose = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (ready) rose = 1;
    end
    check("rst_mid_no_rdy", 64'(rose), 64'd0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      s = 1'($urandom_range(0, 1));
      run_div(a, b, s, bit'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
